dds_param_bank: RTL and testbench

- Parametrised, double-buffered Avalon-MM parameter register bank for the DDS channels. Successor to the single-word PIO output register.
- The CPU writes NUM_CH shadow registers. All channels then commit atomically to the active outputs, either immediately or on the next DDS sync strobe (for example, phase-accumulator wrap).
- Prevents glitches such as an AM mod index and a frequency word being applied on different samples.

---
 rtl/dds_param_bank.sv | 112 +++++++++++
 tb/tb_dds_param_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_param_bank.sv
// dds_param_bank: double-buffered Avalon-MM parameter bank with atomic commit to DDS channels
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   address           word address (shadow 0..NUM_CH-1, CTRL NUM_CH, STATUS NUM_CH+1)
//   chipselect        slave select
//   write_n           active-low write strobe
//   byteenable        write byte lanes
//   writedata         write data
//   readdata          combinational read data
//   sync_strobe       commit sync from the DDS core, honoured only while ARMED
//   out_port          active registers, channel i at [i*DATA_W +: DATA_W]
//   commit_pulse      one cycle high, aligned with the new out_port value
//
// Optional: define DDS_PARAM_BANK_READBACK_EN to map active[i] read-only at 2^(ADDR_W-1)+i.
module dds_param_bank #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     chipselect,
   input  logic                     write_n,
   input  logic [DATA_W/8-1:0]      byteenable,
   input  logic [DATA_W-1:0]        writedata,
   output logic [DATA_W-1:0]        readdata,
   input  logic                     sync_strobe,
   output logic [NUM_CH*DATA_W-1:0] out_port,
   output logic                     commit_pulse
);
   localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_COMMIT = 2'd2;
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH), A_STAT = ADDR_W'(NUM_CH + 1);
`ifdef DDS_PARAM_BANK_READBACK_EN
   localparam int RB_BASE = 1 << (ADDR_W - 1);
`endif
   logic [DATA_W-1:0] shadow [NUM_CH];
   logic [DATA_W-1:0] active [NUM_CH];
   logic [DATA_W-1:0] be_mask, status;
   logic [NUM_CH-1:0] dirty, wr_sel;
   logic [1:0]        state, state_nx;
   logic [7:0]        commit_cnt;
   logic              wr, ctrl_wr, commit;

   assign wr      = chipselect & ~write_n;
   assign commit  = state == S_COMMIT;
   // CTRL writes landing in the commit cycle are dropped
   assign ctrl_wr = wr && address == A_CTRL && !commit;

   always_comb begin
      be_mask = '0;
      for (int b = 0; b < DATA_W / 8; b++) be_mask[b*8 +: 8] = {8{byteenable[b]}};
   end

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) wr_sel[i] = wr && address == ADDR_W'(i);
   end

   // ABORT > COMMIT_NOW > sync_strobe (ARMED only) > ARM; an ARM write cannot see a same-cycle sync
   always_comb begin
      state_nx = state;
      if (state[1]) state_nx = S_IDLE;
      else if (ctrl_wr && writedata[2]) state_nx = S_IDLE;
      else if (ctrl_wr && writedata[0]) state_nx = S_COMMIT;
      else if (state == S_ARMED && sync_strobe) state_nx = S_COMMIT;
      else if (ctrl_wr && writedata[1]) state_nx = S_ARMED;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         dirty        <= '0;
         commit_cnt   <= '0;
         commit_pulse <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= RESET_VAL;
            active[i] <= RESET_VAL;
         end
      end else begin
         state        <= state_nx;
         commit_pulse <= commit;
         // a channel written during the commit cycle keeps its dirty flag
         dirty        <= commit ? wr_sel : dirty | wr_sel;
         if (commit) commit_cnt <= commit_cnt + 8'd1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_sel[i]) shadow[i] <= (shadow[i] & ~be_mask) | (writedata & be_mask);
            if (commit) active[i] <= shadow[i];
         end
      end
   end

   always_comb begin
      status              = '0;
      status[0]           = state == S_ARMED;
      status[15:8]        = commit_cnt;
      status[16 +: NUM_CH] = dirty;
      readdata            = '0;
      for (int i = 0; i < NUM_CH; i++) if (address == ADDR_W'(i)) readdata = shadow[i];
      if (address == A_STAT) readdata = status;
`ifdef DDS_PARAM_BANK_READBACK_EN
      for (int i = 0; i < NUM_CH; i++) if (address == ADDR_W'(RB_BASE + i)) readdata = active[i];
`endif
   end

   always_comb begin
      out_port = '0;
      for (int i = 0; i < NUM_CH; i++) out_port[i*DATA_W +: DATA_W] = active[i];
   end
endmodule

// File: tb/tb_dds_param_bank.sv
// tb_dds_param_bank: scoreboard bench for dds_param_bank, reads and commits checked by a monitor
module tb_dds_param_bank;
   typedef struct { logic [31:0] v; string n; } rd_t;
   typedef struct { logic [127:0] op; int cyc; } op_t;

   logic         clk = 0, reset = 1, chipselect = 0, write_n = 1, sync_strobe = 0, rd_chk = 0;
   logic [3:0]   address = '0, byteenable = '0;
   logic [31:0]  writedata = '0, readdata;
   logic [127:0] out_port;
   logic         commit_pulse;
   logic [31:0]  act [4] = '{default: '0};
   rd_t          rd_q [$];
   op_t          op_q [$];
   rd_t          r;
   op_t          o;
   int           cyc = 0, n_tests = 0, n_fail = 0, n_pulse = 0, exp_pulse = 0;
   logic [31:0]  rb_exp;

   dds_param_bank dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .byteenable(byteenable), .writedata(writedata),
      .readdata(readdata), .sync_strobe(sync_strobe), .out_port(out_port),
      .commit_pulse(commit_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic logic [127:0] pack();
      return {act[3], act[2], act[1], act[0]};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (rd_chk) begin
            if (rd_q.size() == 0) chk("rd_queue_empty", 1, 0);
            else begin
               r = rd_q.pop_front();
               chk(r.n, {96'b0, readdata}, {96'b0, r.v});
            end
         end
         if (commit_pulse) begin
            n_pulse++;
            if (op_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: commit_pulse got 1 expected 0");
            end else begin
               o = op_q.pop_front();
               chk("commit_out", out_port, o.op);
               chk("commit_latency", 128'(cyc), 128'(o.cyc));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      address = a; writedata = d; byteenable = be; chipselect = 1; write_n = 0;
      @(posedge clk); #1;
      chipselect = 0; write_n = 1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
      address = a; chipselect = 1; write_n = 1; rd_chk = 1;
      rd_q.push_back('{e, n});
      @(posedge clk); #1;
      rd_chk = 0; chipselect = 0;
   endtask

   task automatic push_exp();
      op_q.push_back('{pack(), cyc + 2});
      exp_pulse++;
   endtask

   task automatic sync_pulse();
      sync_strobe = 1;
      @(posedge clk); #1;
      sync_strobe = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time got exceeded expected finish");
      $fatal(1);
   end

   initial begin
      idle(3);
      reset = 0;
      chk("reset_out_port", out_port, 0);
      chk("reset_pulse", {127'b0, commit_pulse}, 0);
      rd(5, 32'h0, "reset_status");
      // basic shadow write then immediate commit
      wr(1, 32'h12345678);
      rd(5, 32'h0002_0000, "status_dirty1");
      chk("out_unchanged_before_commit", out_port, 0);
      act[1] = 32'h12345678;
      push_exp();
      wr(4, 32'h1);
      idle(3);
      rd(5, 32'h0000_0100, "status_after_commit1");
      // armed commit on sync strobe
      wr(4, 32'h2);
      rd(5, 32'h0000_0101, "status_armed");
      wr(0, 32'hAA);
      rd(5, 32'h0001_0101, "status_armed_dirty0");
      idle(20);
      chk("out_held_while_armed", out_port, pack());
      act[0] = 32'hAA;
      push_exp();
      sync_pulse();
      idle(2);
      rd(5, 32'h0000_0200, "status_after_sync");
      // abort and priority
      wr(4, 32'h2);
      wr(4, 32'h4);
      rd(5, 32'h0000_0200, "status_aborted");
      sync_pulse();
      idle(3);
      rd(5, 32'h0000_0200, "status_sync_idle_ignored");
      wr(4, 32'h7);
      idle(2);
      rd(5, 32'h0000_0200, "status_ctrl7_idle");
      wr(4, 32'h2);
      wr(4, 32'h7);
      rd(5, 32'h0000_0200, "status_ctrl7_armed");
      chk("pulse_count_abort", 128'(n_pulse), 128'(exp_pulse));
      // byteenable masking; CTRL write in the COMMIT cycle ignored
      wr(2, 32'hFFFF_FFFF);
      wr(2, 32'h0, 4'b0010);
      rd(2, 32'hFFFF_00FF, "shadow2_byteenable");
      rd(5, 32'h0004_0200, "status_dirty2");
      act[2] = 32'hFFFF_00FF;
      push_exp();
      wr(4, 32'h1);
      wr(4, 32'h2);
      idle(2);
      rd(5, 32'h0000_0300, "status_ctrl_in_commit_ignored");
      // shadow write coinciding with the COMMIT cycle
      push_exp();
      wr(4, 32'h1);
      wr(3, 32'h33);
      idle(2);
      rd(5, 32'h0008_0400, "status_dirty3_kept");
      rd(3, 32'h33, "shadow3_value");
      act[3] = 32'h33;
      push_exp();
      wr(4, 32'h1);
      idle(2);
      rd(5, 32'h0000_0500, "status_cnt5");
      // ARM with same-cycle sync: sync ignored, armed next cycle
      sync_strobe = 1;
      wr(4, 32'h2);
      sync_strobe = 0;
      idle(2);
      rd(5, 32'h0000_0501, "status_arm_sync_same_cycle");
      chk("pulse_count_arm_sync", 128'(n_pulse), 128'(exp_pulse));
      wr(4, 32'h4);
      wr(5, 32'hFFFF_FFFF);
      rd(5, 32'h0000_0500, "status_write_ignored");
      rd(4, 32'h0, "ctrl_reads_zero");
      rd(6, 32'h0, "unmapped_reads_zero");
`ifdef DDS_PARAM_BANK_READBACK_EN
      rb_exp = 32'h12345678;
`else
      rb_exp = 32'h0;
`endif
      rd(9, rb_exp, "readback_ch1");
      // counter wrap
      for (int i = 0; i < 250; i++) begin
         push_exp();
         wr(4, 32'h1);
         idle(1);
      end
      idle(2);
      rd(5, 32'h0000_FF00, "status_cnt255");
      push_exp();
      wr(4, 32'h1);
      idle(2);
      rd(5, 32'h0000_0000, "status_cnt_wrap");
      chk("pulse_count_wrap", 128'(n_pulse), 128'(exp_pulse));
      // reset during COMMIT: no pulse, outputs cleared at once
      wr(0, 32'h77);
      wr(4, 32'h1);
      reset = 1;
      #1;
      chk("reset_mid_commit_out", out_port, 0);
      idle(2);
      chk("reset_mid_commit_pulse", {127'b0, commit_pulse}, 0);
      reset = 0;
      act = '{default: '0};
      idle(2);
      chk("pulse_count_reset_commit", 128'(n_pulse), 128'(exp_pulse));
      // reset while ARMED
      wr(1, 32'h99);
      wr(4, 32'h2);
      rd(5, 32'h0002_0001, "status_armed_before_reset");
      address = 5;
      #2;
      reset = 1;
      #1;
      chk("reset_armed_status", {96'b0, readdata}, 0);
      chk("reset_armed_out", out_port, 0);
      @(posedge clk); #1;
      reset = 0;
      sync_pulse();
      idle(3);
      rd(1, 32'h0, "shadow1_after_reset");
      chk("pulse_count_final", 128'(n_pulse), 128'(exp_pulse));
      chk("commit_queue_drained", 128'(op_q.size()), 0);
      chk("read_queue_drained", 128'(rd_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
